// File: rtl/fft_pkg.sv
// Shared constants, FSM encodings and helpers for the FFT output reorder path.
// Defaults match a 16-point, 32-bit radix-2 SDF pipeline.
package fft_pkg;

  localparam int FFT_DATA_W = 32;
  localparam int FFT_N      = 16;
  localparam int FFT_LOG2N  = 4;

  typedef enum logic {
    W_IDLE,
    W_FILL
  } wstate_t;

  typedef enum logic {
    R_IDLE,
    R_DRAIN
  } rstate_t;

  function automatic logic [FFT_LOG2N-1:0] bitrev(
    input logic [FFT_LOG2N-1:0] x
  );
    logic [FFT_LOG2N-1:0] r;
    for (int i = 0; i < FFT_LOG2N; i++)
      r[i] = x[FFT_LOG2N-1-i];
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// The array itself is never reset; only the read register clears.
module fft_reorder_ram #(
  parameter int W  = 64,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)
      rdata <= '0;
    else if (re)
      rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: bit-reversed SDF output in, natural order out.
// One bank fills while the other drains, so frames stream without gaps.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int DATA_W = FFT_DATA_W,
  parameter int N      = FFT_N,
  parameter int LOG2N  = FFT_LOG2N
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_real,
  input  logic [DATA_W-1:0] in_img,
  input  logic              in_start,
  output logic [DATA_W-1:0] out_real,
  output logic [DATA_W-1:0] out_img,
  output logic              out_valid,
  output logic              out_start,
  output logic              out_last,
  output logic              frame_abort
);

  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);
  localparam logic [LOG2N-1:0] ONE  = LOG2N'(1);

  wstate_t            wstate;
  rstate_t            rstate;
  logic [LOG2N-1:0]   wcnt;
  logic [LOG2N-1:0]   rcnt;
  logic [LOG2N-1:0]   rrev;
  logic [LOG2N-1:0]   wlo;
  logic               wbank;
  logic               rbank;
  logic               done_bank;
  logic               frame_done;
  logic               last_w;
  logic               we;
  logic               re;
  logic [2*DATA_W-1:0] rdata;

  assign last_w = (wstate == W_FILL) && (wcnt == LAST);
  assign we     = in_start || (wstate == W_FILL);
  // A start pulse always targets slot 0 unless it coincides with the last slot
  assign wlo    = (in_start && !last_w) ? '0 : wcnt;
  assign re     = (rstate == R_DRAIN);

  for (genvar i = 0; i < LOG2N; i++) begin : g_rev
    assign rrev[i] = rcnt[LOG2N-1-i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wstate      <= W_IDLE;
      wcnt        <= '0;
      wbank       <= 1'b0;
      done_bank   <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      unique case (wstate)
        W_IDLE: begin
          if (in_start) begin
            wcnt   <= ONE;
            wstate <= W_FILL;
          end
        end
        W_FILL: begin
          if (last_w) begin
            wbank      <= ~wbank;
            done_bank  <= wbank;
            frame_done <= 1'b1;
            wcnt       <= '0;
            wstate     <= in_start ? W_FILL : W_IDLE;
          end else if (in_start) begin
            frame_abort <= 1'b1;
            wcnt        <= ONE;
          end else begin
            wcnt <= wcnt + ONE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rstate    <= R_IDLE;
      rcnt      <= '0;
      rbank     <= 1'b0;
      out_valid <= 1'b0;
      out_start <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= re;
      out_start <= re && (rcnt == '0);
      out_last  <= re && (rcnt == LAST);
      unique case (rstate)
        R_IDLE: begin
          if (frame_done) begin
            rbank  <= done_bank;
            rcnt   <= '0;
            rstate <= R_DRAIN;
          end
        end
        R_DRAIN: begin
          rcnt <= rcnt + ONE;
          if (rcnt == LAST) begin
            if (frame_done)
              rbank <= done_bank;
            else
              rstate <= R_IDLE;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  fft_reorder_ram #(
    .W  (2 * DATA_W),
    .AW (LOG2N + 1)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr ({wbank, wlo}),
    .wdata ({in_real, in_img}),
    .re    (re),
    .raddr ({rbank, rrev}),
    .rdata (rdata)
  );

  assign out_real = rdata[2*DATA_W-1:DATA_W];
  assign out_img  = rdata[DATA_W-1:0];

endmodule
